// File: rtl/mole_pkg.sv
// mole_pkg: shared types and constants for the hit-the-target game block.
//   mole_state_e : target FSM states (MOLE_IDLE, MOLE_LIT)
//   TIMER_W      : width of the LED window timer
package mole_pkg;

    typedef enum logic [0:0] {
        MOLE_IDLE = 1'b0,
        MOLE_LIT  = 1'b1
    } mole_state_e;

    localparam int TIMER_W = 32;

endpackage

// File: rtl/mole_target_button_debounce.sv
// button_debounce: turns a raw asynchronous push button into a single-cycle
// press pulse.
//   clk       in  system clock (rising edge)
//   rst_n     in  asynchronous active-low reset
//   button_i  in  raw active-high button
//   press_o   out one-cycle pulse per debounced rising edge
// Path: 2-flop synchronizer -> level debouncer (DB_CYCLES of stability)
// -> registered rising-edge detector.
module button_debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_i,
    output logic press_o
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic             sync1_q;
    logic             sync2_q;
    logic             db_q;
    logic             db_d;
    logic             db_dly_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter tracks how long the synchronized input has disagreed with
    // the debounced level; any agreement restarts the count.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
            db_d  = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= button_i;
            sync2_q  <= sync1_q;
            db_q     <= db_d;
            cnt_q    <= cnt_d;
            db_dly_q <= db_q;
            press_q  <= db_q & ~db_dly_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/mole_target.sv
// mole_target: lights a target LED for ON_CYCLES after each accepted spawn and
// scores a hit (debounced press inside the window) or a miss (window expiry).
//   clk, rst_n   clock, asynchronous active-low reset
//   enable       game running; low forces IDLE with no scoring
//   spawn        single-cycle spawn request (ignored while lit)
//   button       raw asynchronous push button
//   score_clr    synchronous score clear (beats any increment/decrement)
//   led          target lit
//   hit/miss     one-cycle pulses, coincident with the led falling
//   whiff        one-cycle pulse on a press with no target lit
//   score        saturating score, SCORE_W bits
// Build option MOLE_PENALTY_EN: when defined, a whiff pulses `whiff` and
// decrements the score (saturating at 0); otherwise `whiff` is tied low and
// presses in IDLE do nothing.
module mole_target
    import mole_pkg::*;
#(
    parameter int ON_CYCLES = 100_000_000,
    parameter int DB_CYCLES = 1_000_000,
    parameter int SCORE_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               spawn,
    input  logic               button,
    input  logic               score_clr,
    output logic               led,
    output logic               hit,
    output logic               miss,
    output logic               whiff,
    output logic [SCORE_W-1:0] score
);

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [TIMER_W-1:0] TIMER_END = TIMER_W'(ON_CYCLES - 1);

    logic               press;
    mole_state_e        state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               led_q, led_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;
    logic               whiff_q, whiff_d;
    logic [SCORE_W-1:0] score_q, score_d;

    button_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_button_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .button_i (button),
        .press_o  (press)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        led_d   = led_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        whiff_d = 1'b0;
        score_d = score_q;

        if (!enable) begin
            state_d = MOLE_IDLE;
            timer_d = '0;
            led_d   = 1'b0;
        end else begin
            case (state_q)
                MOLE_IDLE: begin
                    // A press coinciding with an accepted spawn is dropped.
                    if (spawn) begin
                        state_d = MOLE_LIT;
                        timer_d = '0;
                        led_d   = 1'b1;
                    end else if (press) begin
`ifdef MOLE_PENALTY_EN
                        whiff_d = 1'b1;
                        if (score_q != '0) begin
                            score_d = score_q - SCORE_W'(1);
                        end
`else
                        // No penalty: a press with no target is harmless.
                        whiff_d = 1'b0;
`endif
                    end
                end
                MOLE_LIT: begin
                    // Press is tested first so it wins on the final cycle.
                    if (press) begin
                        state_d = MOLE_IDLE;
                        timer_d = '0;
                        led_d   = 1'b0;
                        hit_d   = 1'b1;
                        if (score_q != SCORE_MAX) begin
                            score_d = score_q + SCORE_W'(1);
                        end
                    end else if (timer_q == TIMER_END) begin
                        state_d = MOLE_IDLE;
                        timer_d = '0;
                        led_d   = 1'b0;
                        miss_d  = 1'b1;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
                default: begin
                    state_d = MOLE_IDLE;
                    timer_d = '0;
                    led_d   = 1'b0;
                end
            endcase
        end

        if (score_clr) begin
            score_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MOLE_IDLE;
            timer_q <= '0;
            led_q   <= 1'b0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            whiff_q <= 1'b0;
            score_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            led_q   <= led_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            whiff_q <= whiff_d;
            score_q <= score_d;
        end
    end

    assign led   = led_q;
    assign hit   = hit_q;
    assign miss  = miss_q;
    assign score = score_q;

`ifdef MOLE_PENALTY_EN
    assign whiff = whiff_q;
`else
    assign whiff = 1'b0;
`endif

endmodule

// File: tb/tb_mole_target.sv
// tb_mole_target: self-checking bench for mole_target (ON_CYCLES=10,
// DB_CYCLES=4). A cycle-level reference model built from the game rules is
// compared against the DUT after every clock edge; directed sequences add
// constant-valued checks for the corner cases.
module tb_mole_target;

    localparam int ON   = 10;
    localparam int DB   = 4;
    localparam int SW   = 8;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          spawn = 1'b0;
    logic          button = 1'b0;
    logic          score_clr = 1'b0;
    logic          led, hit, miss, whiff;
    logic [SW-1:0] score;

    int n_cmp = 0;
    int n_bad = 0;

    mole_target #(
        .ON_CYCLES (ON),
        .DB_CYCLES (DB),
        .SCORE_W   (SW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .spawn     (spawn),
        .button    (button),
        .score_clr (score_clr),
        .led       (led),
        .hit       (hit),
        .miss      (miss),
        .whiff     (whiff),
        .score     (score)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Button: history of samples; the debounced level flips once the
    // synchronized samples (two edges old) have all differed from it for DB
    // edges. A debounced rise reaches the game logic two edges later.
    // Window: the led expires ON edges after the accepting spawn edge.
    int cyc;
    bit m_lit;
    int m_spawn_edge;
    int m_score;
    bit m_hit, m_miss, m_whiff;
    bit hist[$];
    bit m_db;
    bit m_rise_prev;
    bit m_pending;

    task automatic model_reset();
        cyc = 0; m_lit = 0; m_spawn_edge = 0; m_score = 0;
        m_hit = 0; m_miss = 0; m_whiff = 0;
        hist.delete();
        for (int i = 0; i < DB + 4; i++) hist.push_back(1'b0);
        m_db = 0; m_rise_prev = 0; m_pending = 0;
    endtask

    task automatic model_edge();
        bit press_now;
        bit flip;
        press_now = m_pending;
        hist.push_back(button);
        if (hist.size() > DB + 4) void'(hist.pop_front());
        flip = 1;
        for (int i = 0; i < DB; i++)
            if (hist[hist.size() - 3 - i] == m_db) flip = 0;
        m_pending   = m_rise_prev;
        m_rise_prev = flip && !m_db;
        if (flip) m_db = !m_db;

        m_hit = 0; m_miss = 0; m_whiff = 0;
        if (!enable) begin
            m_lit = 0;
        end else if (!m_lit) begin
            if (spawn) begin
                m_lit = 1;
                m_spawn_edge = cyc;
            end else if (press_now) begin
`ifdef MOLE_PENALTY_EN
                m_whiff = 1;
                if (m_score > 0) m_score--;
`endif
            end
        end else if (press_now) begin
            m_lit = 0;
            m_hit = 1;
            if (m_score < SMAX) m_score++;
        end else if (cyc - m_spawn_edge == ON) begin
            m_lit = 0;
            m_miss = 1;
        end
        if (score_clr) m_score = 0;
        cyc++;
    endtask

    function automatic int model_vec();
        return (int'(m_lit) << (SW + 3)) | (int'(m_hit) << (SW + 2)) |
               (int'(m_miss) << (SW + 1)) | (int'(m_whiff) << SW) | m_score;
    endfunction

    function automatic int dut_vec();
        return int'({led, hit, miss, whiff, score});
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("model", dut_vec(), model_vec());
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Raise the button so its press lands on the third LIT edge after a spawn.
    task automatic do_hit(input bit clr);
        button = 0; ticks(8);
        button = 1; ticks(4);
        spawn = 1; tick();
        spawn = 0; ticks(2);
        score_clr = clr; tick();
        score_clr = 0;
        button = 0;
    endtask

    typedef struct {
        bit spawn;
        bit exp_led;
        bit exp_miss;
        int exp_score;
    } vec_t;

    initial begin
        vec_t vt[20];
        int nh, nm, nw;

        // ---- reset ----
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", dut_vec(), 0);
        @(negedge clk);
        rst_n = 1;
        enable = 1;

        // ---- table: spawn at cycle 5, no press -> miss ----
        for (int c = 0; c < 20; c++) begin
            vt[c].spawn     = (c == 5);
            vt[c].exp_led   = (c + 1 >= 6) && (c + 1 <= 15);
            vt[c].exp_miss  = (c + 1 == 16);
            vt[c].exp_score = 0;
        end
        for (int c = 0; c < 20; c++) begin
            spawn = vt[c].spawn;
            tick();
            chk("t1_led", int'(led), int'(vt[c].exp_led));
            chk("t1_miss", int'(miss), int'(vt[c].exp_miss));
            chk("t1_score", int'(score), vt[c].exp_score);
        end
        spawn = 0;

        // ---- hit three cycles into LIT ----
        button = 1; ticks(4);
        spawn = 1; tick();
        spawn = 0; ticks(2);
        chk("t2_led_before", int'(led), 1);
        chk("t2_hit_before", int'(hit), 0);
        tick();
        chk("t2_hit", int'(hit), 1);
        chk("t2_led_low", int'(led), 0);
        chk("t2_score", int'(score), 1);
        tick();
        chk("t2_hit_once", int'(hit), 0);
        chk("t2_no_miss", int'(miss), 0);
        button = 0; ticks(8);

        // ---- press on the final LIT cycle ----
        spawn = 1; tick();
        spawn = 0; ticks(2);
        button = 1; ticks(7);
        chk("t3_led_last", int'(led), 1);
        tick();
        chk("t3_hit", int'(hit), 1);
        chk("t3_miss", int'(miss), 0);
        chk("t3_score", int'(score), 2);
        tick();
        chk("t3_no_late_miss", int'(miss), 0);
        button = 0; ticks(8);

        // ---- saturation and clear ----
        for (int i = 0; i < SMAX - 2; i++) do_hit(0);
        chk("t4_score_max", int'(score), SMAX);
        do_hit(0);
        chk("t4_sat_hit", int'(hit), 1);
        chk("t4_sat_score", int'(score), SMAX);
        do_hit(1);
        chk("t4_clr_hit", int'(hit), 1);
        chk("t4_clr_score", int'(score), 0);

        // ---- bouncing button ----
        ticks(8);
        nh = 0; nm = 0;
        spawn = 1; tick();
        spawn = 0;
        for (int i = 0; i < 40; i++) begin
            button = ((i / 2) % 2) != 0;
            tick();
            if (hit) nh++;
            if (miss) nm++;
        end
        button = 0;
        chk("t5_bounce_hits", nh, 0);
        chk("t5_bounce_misses", nm, 1);

        // ---- enable dropped mid-window ----
        do_hit(0);
        ticks(8);
        spawn = 1; tick();
        spawn = 0; ticks(3);
        enable = 0; tick();
        chk("t5_en_led", int'(led), 0);
        chk("t5_en_miss", int'(miss), 0);
        chk("t5_en_score", int'(score), 1);
        tick();
        enable = 1;
        nm = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (miss) nm++;
        end
        chk("t5_en_no_miss", nm, 0);

        // ---- press with no target lit ----
        score_clr = 1; tick();
        score_clr = 0;
        for (int i = 0; i < 3; i++) do_hit(0);
        chk("t6_score3", int'(score), 3);
        ticks(8);
        nw = 0;
        button = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (whiff) nw++;
        end
        button = 0; ticks(8);
`ifdef MOLE_PENALTY_EN
        chk("t6_whiff_count", nw, 1);
        chk("t6_whiff_score", int'(score), 2);
`else
        chk("t6_whiff_count", nw, 0);
        chk("t6_whiff_score", int'(score), 3);
`endif
        score_clr = 1; tick();
        score_clr = 0;
        nw = 0;
        button = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (whiff) nw++;
        end
        button = 0; ticks(8);
        chk("t6_zero_score", int'(score), 0);
`ifdef MOLE_PENALTY_EN
        chk("t6_zero_whiff", nw, 1);
`else
        chk("t6_zero_whiff", nw, 0);
`endif

        // ---- randomized run against the model ----
        for (int i = 0; i < 3000; i++) begin
            enable    = ($urandom_range(15) != 0);
            spawn     = ($urandom_range(7) == 0);
            score_clr = ($urandom_range(63) == 0);
            if ($urandom_range(5) == 0) button = ~button;
            tick();
        end

        // ---- asynchronous reset mid-window ----
        enable = 1; spawn = 0; score_clr = 0;
        do_hit(0);
        ticks(8);
        spawn = 1; tick();
        spawn = 0; ticks(2);
        chk("t7_led_lit", int'(led), 1);
        #3;
        rst_n = 0;
        #1;
        chk("t7_async_reset", dut_vec(), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        ticks(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
